// File: rtl/dmem_responder.sv
`default_nettype none
// ============================================================================
// Module   : dmem_responder
// Purpose  : Multi-cycle, handshaked data-memory target for the MIPS core.
//            Accepts one load/store at a time over a valid/ready request
//            channel, waits a fixed LATENCY, performs the access and returns
//            the result over a valid/ready response channel. Misaligned or
//            out-of-range accesses are flagged with resp_err and not performed.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters:
//   DEPTH      number of 32-bit words stored (power of two, 4..1024)
//   LATENCY    cycles from request acceptance to response valid (1..15)
// Ports:
//   clk        system clock, rising edge
//   reset      synchronous reset, active low (0 = reset)
//   req_valid  initiator presents a request
//   req_ready  responder can accept a request this cycle
//   req_write  1 = store, 0 = load
//   req_addr   byte address
//   req_wdata  store data
//   req_be     store byte enables, bit i selects lane bits 8i+7:8i
//   resp_valid response available
//   resp_ready initiator accepts the response
//   resp_rdata load data; 0 for stores and errors
//   resp_err   1 = request rejected (misaligned or out of range)
// ============================================================================
module dmem_responder #(
  parameter int DEPTH   = 64,
  parameter int LATENCY = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_be,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err
);

  localparam int          c_AW       = $clog2(DEPTH);
  localparam logic [31:0] c_LIMIT    = 32'(4 * DEPTH);
  localparam logic [3:0]  c_CNT_INIT = 4'(LATENCY - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic [3:0]      r_cnt;
  logic            r_write;
  logic [31:0]     r_addr;
  logic [31:0]     r_wdata;
  logic [3:0]      r_be;
  logic [31:0]     r_rdata;
  logic            r_err;
  logic [31:0]     r_mem [DEPTH];

  logic            w_accept;
  logic            w_done;
  logic            w_err;
  logic            w_commit;
  logic [c_AW-1:0] w_idx;

  assign w_accept = req_valid & req_ready;
  assign w_done   = (r_state == ST_WAIT) && (r_cnt == 4'd0);
  // Upper address bits take no part in indexing; the range test alone
  // rejects them, so no out-of-range address can alias onto a real word.
  assign w_err    = (r_addr[1:0] != 2'b00) || (r_addr >= c_LIMIT);
  assign w_idx    = r_addr[c_AW+1:2];
  // A store still pending when reset arrives must never reach storage,
  // hence the explicit reset term.
  assign w_commit = reset & w_done & r_write & ~w_err;

  assign resp_rdata = r_rdata;
  assign resp_err   = r_err;

  // --------------------------------------------------------------------------
  // FSM state register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // --------------------------------------------------------------------------
  // FSM next-state and handshake outputs
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_nxt = r_state;
    req_ready   = 1'b0;
    resp_valid  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        // Ready is gated by reset so nothing is advertised during reset.
        req_ready = reset;
        if (req_valid && reset) begin
          w_state_nxt = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (r_cnt == 4'd0) begin
          w_state_nxt = ST_RESP;
        end
      end
      ST_RESP: begin
        resp_valid = 1'b1;
        if (resp_ready) begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Wait counter and response registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_cnt   <= 4'd0;
      r_rdata <= 32'd0;
      r_err   <= 1'b0;
    end else begin
      if (w_accept) begin
        r_cnt <= c_CNT_INIT;
      end else if ((r_state == ST_WAIT) && (r_cnt != 4'd0)) begin
        r_cnt <= 4'(r_cnt - 4'd1);
      end

      if (w_done) begin
        r_err   <= w_err;
        r_rdata <= (!w_err && !r_write) ? r_mem[w_idx] : 32'd0;
      end else if ((r_state == ST_RESP) && resp_ready) begin
        r_rdata <= 32'd0;
        r_err   <= 1'b0;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Request capture. Only loaded on acceptance, so request-side activity
  // during WAIT/RESP cannot disturb the transaction in flight.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_write <= req_write;
      r_addr  <= req_addr;
      r_wdata <= req_wdata;
      r_be    <= req_be;
    end
  end

  // --------------------------------------------------------------------------
  // Storage: not cleared by reset, byte-lane write at the completion edge
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (w_commit) begin
      for (int i = 0; i < 4; i++) begin
        if (r_be[i]) begin
          r_mem[w_idx][8*i +: 8] <= r_wdata[8*i +: 8];
        end
      end
    end
  end

endmodule
`default_nettype wire
